ascon_piso: RTL and testbench
=============================

Name: ascon_piso

Overview:
- Output serializer that sits directly upstream of the bench-side sipo, inside the ascon_spi output path.
- Buffers 32-bit result words from the Ascon core (hash, tag, ciphertext) in a small FIFO.
- Shifts each word out MSB-first on sdo, with valid framing each word.
- Drops valid for a programmable gap between words, so the downstream sipo presents each word on its pdo.

Parameters:
- WIDTH, 32, bits per serialized word.
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- GAP, 2, idle cycles with valid low between consecutive words; at least 1.

Ports:
- clk  input  1  interface clock; every flop is posedge clk.
- rst  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  word from the core.
- in_valid  input  1  in_data is offered this cycle.
- in_ready  output  1  FIFO can accept a word; equals !full.
- valid  output  1  frames a word on sdo; high for exactly WIDTH consecutive cycles per word.
- sdo  output  1  serial data, MSB first; 0 whenever valid is low.
- count  output  $clog2(DEPTH+1)  words currently held in the FIFO, excluding the word being shifted.
- busy  output  1  high when state is not IDLE or count is not 0.

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, state=IDLE, shift register=0, valid=0, sdo=0, busy=0, in_ready=1.
- A word is accepted on a posedge where in_valid && in_ready. in_data is sampled at that edge and count increments.
- in_ready is combinational from full only. When full, a push is refused even if a pop occurs on the same edge.
- valid and sdo are registered: valid = (state==SHIFT); sdo = shreg[WIDTH-1] while in SHIFT, otherwise 0.
- FSM: IDLE, SHIFT, GAP.
- IDLE: if count is not 0 at an edge, pop the head into shreg, set bitcnt=WIDTH-1 and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each edge, shreg <= shreg<<1.
  - If bitcnt is not 0, decrement bitcnt.
  - If bitcnt==0, set gapcnt=GAP-1 and go to GAP.
- GAP: valid low.
  - If gapcnt is not 0, decrement gapcnt.
  - If gapcnt==0 and count is not 0, pop directly into shreg, set bitcnt=WIDTH-1 and go to SHIFT.
  - If gapcnt==0 and count==0, go to IDLE.
- Latency: a word pushed at edge k into an empty, idle block pops at edge k+1. valid is high from after k+1 through the cycle ending at edge k+1+WIDTH. The MSB is on sdo in the first valid cycle.
- Back-to-back words: valid is low for exactly GAP cycles between words. There is no extra IDLE cycle.
- A push and a pop on the same edge leave count unchanged.
- A push into an empty FIFO is not visible to IDLE until the next edge, so there is no same-cycle bypass.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH); empty = (count==0).
- Reset asserted mid-word drops the partial word and all buffered words. valid falls without waiting for a clock edge.
- in_data is ignored when in_valid is low or in_ready is low. No overflow is possible.

Test Plan:
- Reset, then push 0xA5A5_0F0F -> valid high 32 cycles starting 1 cycle after the push edge. sdo sequence is 1,0,1,0,0,1,0,1,...,1,1,1,1. The bench sipo pdo reads 0xA5A5_0F0F after valid falls.
- Push 0x0000_0001 and 0xFFFF_FFFE on consecutive cycles -> two 32-cycle valid frames separated by exactly 2 low cycles. sipo outputs 0x00000001 then 0xFFFFFFFE. count goes 1,1,0, because the first push is popped on the next edge while the second is accepted.
- Hold in_valid for 6 cycles with data 1..6 while the first word is shifting -> the FIFO accepts 4 words plus the one popped. in_ready drops when count=4, so word 6 is refused until a pop. The output order is 1..5, and 6 appears only if it is re-offered.
- Assert rst at bit 10 of word 0xDEAD_BEEF with 2 words queued -> valid=0, sdo=0 and count=0 immediately. No further frames appear after rst is released.
- Hold in_valid low after the last word -> after the final GAP cycles the state is IDLE, busy=0 and in_ready=1. sdo stays 0 for 100 cycles.
- Parameter sweep with GAP=1 and DEPTH=2 -> the inter-word low time is exactly 1 cycle, and in_ready deasserts at count=2.

Source files
------------

// File: rtl/ascon_piso.sv
// ascon_piso: buffers result words from the Ascon core in a small FIFO and
// shifts each one out MSB-first on sdo. valid frames each word, and valid is
// held low for GAP cycles between words.
// Ports:
//   clk, rst            interface clock, asynchronous active-high reset
//   in_data, in_valid   word offered by the core
//   in_ready            FIFO not full (combinational)
//   valid, sdo          serial frame: WIDTH cycles of valid, MSB first
//   count               words buffered, not counting the one being shifted
//   busy                serializer active or FIFO non-empty
module ascon_piso #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       valid,
  output logic                       sdo,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP > 2) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               pop, push, load_gap, full, empty;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BIT_W-1:0]   bitcnt_q;
  logic [GAP_W-1:0]   gapcnt_q;

  // A push is refused when full, even if a pop happens on the same edge.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign count = count_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and FIFO pop control
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_gap = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bitcnt_q == '0) begin
          load_gap = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        // Pop straight from GAP so back-to-back words see no extra idle cycle
        if (gapcnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; reset clears them without a clock
  always_comb begin
    valid    = (state_q == ST_SHIFT);
    sdo      = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    busy     = (state_q != ST_IDLE) || !empty;
    in_ready = !full;
  end

  // Shift register and bit/gap counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      if (pop) begin
        shreg_q  <= mem[rd_ptr_q];
        bitcnt_q <= BIT_W'(WIDTH - 1);
      end else if (state_q == ST_SHIFT) begin
        shreg_q <= shreg_q << 1;
        if (bitcnt_q != '0) bitcnt_q <= bitcnt_q - BIT_W'(1);
      end
      if (load_gap) begin
        gapcnt_q <= GAP_W'(GAP - 1);
      end else if (state_q == ST_GAP && gapcnt_q != '0) begin
        gapcnt_q <= gapcnt_q - GAP_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while count is 0
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  // FIFO pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_piso.sv
// Bench for ascon_piso: two instances (defaults, and GAP=1/DEPTH=2) share one
// stimulus stream; a timeline model of pops and frames predicts every output.
module tb_ascon_piso;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;

  logic       in_ready0, valid0, sdo0, busy0;
  logic [2:0] count0;
  logic       in_ready1, valid1, sdo1, busy1;
  logic [1:0] count1;

  always #5 clk = ~clk;

  ascon_piso #(.WIDTH(32), .DEPTH(4), .GAP(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .valid(valid0), .sdo(sdo0), .count(count0), .busy(busy0)
  );

  ascon_piso #(.WIDTH(32), .DEPTH(2), .GAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .valid(valid1), .sdo(sdo1), .count(count1), .busy(busy1)
  );

  // Bench-side sipo on instance 0
  logic [31:0] pdo0 = '0;
  always @(posedge clk) if (valid0) pdo0 <= {pdo0[30:0], sdo0};

  // Model: per-instance FIFO contents, edge of last pop, word being shifted
  int          nvec = 0;
  int          nmis = 0;
  int          e = 0;
  int          sz [2];
  int          hd [2];
  int          lp [2];
  logic [31:0] mbuf [2][16];
  logic [31:0] cw [2];

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int gp(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, i, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sz[i] = 0;
      hd[i] = 0;
      lp[i] = -1000000;
      cw[i] = '0;
    end
  endtask

  // One clock edge: a pop happens when words are waiting and the previous
  // frame plus its gap has elapsed; a push needs room before this edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic acc;
      acc = in_valid && (sz[i] < dep(i));
      if (sz[i] > 0 && e >= lp[i] + W + gp(i)) begin
        cw[i] = mbuf[i][hd[i]];
        hd[i] = (hd[i] + 1) % 16;
        sz[i]--;
        lp[i] = e;
      end
      if (acc) begin
        mbuf[i][(hd[i] + sz[i]) % 16] = in_data;
        sz[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int          d;
      logic        ev, es, eb;
      logic [31:0] ov, os, oc, orr, ob;
      d  = e - lp[i];
      ev = (d < W);
      es = 1'b0;
      if (ev) es = cw[i][W-1-d];
      eb = (d < W + gp(i)) || (sz[i] != 0);
      ov  = (i == 0) ? 32'(valid0)    : 32'(valid1);
      os  = (i == 0) ? 32'(sdo0)      : 32'(sdo1);
      oc  = (i == 0) ? 32'(count0)    : 32'(count1);
      orr = (i == 0) ? 32'(in_ready0) : 32'(in_ready1);
      ob  = (i == 0) ? 32'(busy0)     : 32'(busy1);
      chk("valid", i, ov, 32'(ev));
      chk("sdo", i, os, 32'(es));
      chk("count", i, oc, 32'(sz[i]));
      chk("in_ready", i, orr, 32'(sz[i] < dep(i)));
      chk("busy", i, ob, 32'(eb));
      if (i == 0 && d == W) chk("pdo", 0, pdo0, cw[0]);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom);
  endtask

  // Entered just after an edge; rst takes effect without a clock
  task automatic async_reset(input int cycles);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      e++;
      #1;
      check_all();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // Power-on reset
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      e++;
      #1;
      check_all();
    end
    rst = 1'b0;

    // Single word
    step(1'b1, 32'hA5A5_0F0F);
    idle(40);

    // Back-to-back words
    step(1'b1, 32'h0000_0001);
    step(1'b1, 32'hFFFF_FFFE);
    idle(80);

    // Overfill while the first word shifts, then re-offer word 6
    for (int k = 1; k <= 6; k++) step(1'b1, 32'(k));
    idle(30);
    step(1'b1, 32'd6);
    idle(250);

    // Reset mid-word with two words queued
    step(1'b1, 32'hDEAD_BEEF);
    step(1'b1, 32'h0000_0011);
    step(1'b1, 32'h0000_0022);
    idle(9);
    async_reset(3);
    idle(100);

    // Random traffic, bursty and sparse
    for (int k = 0; k < 600; k++) step(1'b1, $urandom);
    for (int k = 0; k < 800; k++) step(($urandom % 3) == 0, $urandom);
    idle(150);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
